iob_sim_trap_monitor: RTL and testbench
=======================================

IOB_SIM_TRAP_MONITOR -- requirements
Module: iob_sim_trap_monitor

Interface
REQ-001 Parameters SHALL be:
  - N_TRAP, default 2: number of monitored CPU trap lines.
  - GRACE_CYCLES, default 10: cycles between the finish decision and done_o.
  - TIMEOUT_W, default 32: width of the watchdog and cycle counters.
  - TIMEOUT_CYCLES, default 0: idle cycles before a timeout; 0 disables the watchdog.
REQ-002 Ports SHALL be:
  - clk_i  in  1  system clock.
  - arst_i  in  1  asynchronous, active-high reset.
  - cke_i  in  1  clock enable; when low, all state holds.
  - en_i  in  1  monitor enable.
  - clear_i  in  1  synchronous return to IDLE.
  - trap_i  in  N_TRAP  per-CPU trap levels.
  - activity_i  in  1  watchdog kick (e.g. tester UART rvalid).
  - done_o  out  1  simulation may finish.
  - cause_o  out  2  finish cause: 0 none, 1 trap, 2 timeout, 3 both.
  - trap_mask_o  out  N_TRAP  traps whose rising edges were seen.
  - first_trap_o  out  $clog2(N_TRAP) (min 1)  index of the first trap.
  - cycle_cnt_o  out  TIMEOUT_W  RUN-cycle count.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, GRACE and DONE; all transitions occur on clk_i edges with cke_i=1.
REQ-004 Transitions SHALL be:
  - IDLE->RUN when en_i=1.
  - RUN->IDLE when en_i=0.
  - RUN->GRACE on any trap edge or on a timeout.
  - GRACE->DONE when the grace counter reaches 0.
  - any state->IDLE when clear_i=1; clear_i overrides all other conditions.
REQ-005 Trap edge detection SHALL be: edge[i] = trap_i[i] & ~trap_q[i]. trap_q updates every enabled cycle in every state; it is reset to 0 and cleared to 0 on entry to IDLE, so a trap already high at RUN entry counts as an edge.
REQ-006 On the RUN->GRACE trap transition:
  - trap_mask_o SHALL load the edge vector;
  - first_trap_o SHALL load the lowest set index of that vector;
  - cause_o bit0 SHALL set.
REQ-007 In GRACE, new edges SHALL OR into trap_mask_o; first_trap_o and cause_o SHALL stay unchanged.
REQ-008 The watchdog counter SHALL clear on activity_i=1 and increment otherwise, only in RUN. Timeout fires when counter == TIMEOUT_CYCLES-1 with activity_i=0. Timeout sets cause_o bit1. With TIMEOUT_CYCLES=0 the watchdog never fires.
REQ-009 If a trap edge and a timeout occur in the same cycle, cause_o SHALL become 3 and first_trap_o SHALL follow REQ-006.
REQ-010 The grace counter SHALL load GRACE_CYCLES on GRACE entry and decrement each GRACE cycle. With GRACE_CYCLES=0, GRACE lasts exactly 1 cycle.
REQ-011 done_o SHALL be registered, high only in DONE, and sticky until clear_i or reset.
REQ-012 cycle_cnt_o SHALL increment each RUN cycle, saturate at all-ones, hold in GRACE and DONE, and clear on entry to IDLE.
REQ-013 When cke_i=0, all registers SHALL hold, including edge detect and counters.
REQ-014 The block SHALL make no $finish call; the bench acts on done_o.

Reset
REQ-015 Asserting arst_i SHALL asynchronously force the following within the same cycle, including mid-GRACE:
  - state = IDLE;
  - done_o = 0, cause_o = 0, trap_mask_o = 0, first_trap_o = 0, cycle_cnt_o = 0;
  - trap_q = 0, watchdog = 0, grace counter = 0.
REQ-016 After arst_i deasserts, the block SHALL resume only via REQ-004 (IDLE->RUN needs en_i=1).

Structure
REQ-017 Cause encodings (NONE, TRAP, TIMEOUT, BOTH) and FSM state encodings SHALL live in a shared package/header, iob_sim_trap_monitor_pkg.
REQ-018 The lowest-index priority encoder SHALL be one sub-module, iob_prio_enc, parametrised by width.

Verification
REQ-019 Single trap: N_TRAP=2, GRACE_CYCLES=10, en_i=1, trap_i[1] rises at RUN cycle 50 -> done_o=1 exactly 11 cycles later; cause_o=1; trap_mask_o=2'b10; first_trap_o=1; cycle_cnt_o=50.
REQ-020 Both traps during grace: trap_i[0] rises, then trap_i[1] rises 3 cycles later -> first_trap_o=0; trap_mask_o=2'b11 at done.
REQ-021 Timeout: TIMEOUT_CYCLES=100, activity_i pulsed at cycle 40 and then held 0 -> timeout fires 100 cycles after the pulse; cause_o=2; trap_mask_o=0.
REQ-022 Simultaneous events: trap edge on the timeout cycle -> cause_o=3; first_trap_o=lowest index.
REQ-023 Reset and cke:
  - arst_i pulsed at GRACE count 5 -> all outputs 0 and state IDLE immediately;
  - cke_i=0 for 20 cycles in RUN -> cycle_cnt_o unchanged.
REQ-024 Pre-asserted trap: trap_i[0]=1 before en_i rises -> GRACE entered on the first RUN cycle; clear_i in DONE -> done_o=0 next cycle.

Source files
------------

// File: rtl/iob_sim_trap_monitor_pkg.sv
// Shared encodings for the simulation trap monitor: FSM states, finish causes
// and the index-width helper used for first_trap_o.
package iob_sim_trap_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GRACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TRAP    = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_BOTH    = 2'd3
  } cause_t;

  // Index width for an n-wide vector, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_prio_enc.sv
// Lowest-index-wins priority encoder; hit flags a non-zero input.
module iob_prio_enc #(
  parameter int W     = 2,
  parameter int IDX_W = 1
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign hit = |vec;

endmodule

// File: rtl/iob_sim_trap_monitor.sv
// Simulation finish monitor: watches CPU trap lines and an activity watchdog,
// then after a grace period raises a sticky done_o with the finish cause.
module iob_sim_trap_monitor
  import iob_sim_trap_monitor_pkg::*;
#(
  parameter int N_TRAP         = 2,
  parameter int GRACE_CYCLES   = 10,
  parameter int TIMEOUT_W      = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  input  logic                           cke_i,
  input  logic                           en_i,
  input  logic                           clear_i,
  input  logic [N_TRAP-1:0]              trap_i,
  input  logic                           activity_i,
  output logic                           done_o,
  output logic [1:0]                     cause_o,
  output logic [N_TRAP-1:0]              trap_mask_o,
  output logic [idx_width(N_TRAP)-1:0]   first_trap_o,
  output logic [TIMEOUT_W-1:0]           cycle_cnt_o
);

  localparam int FT_W = idx_width(N_TRAP);
  localparam int GC_W = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;

  state_t              state, state_n;
  logic [N_TRAP-1:0]   trap_q;
  logic [N_TRAP-1:0]   trap_edge;
  logic [TIMEOUT_W-1:0] wdog;
  logic [GC_W-1:0]     grace_cnt;
  logic [FT_W-1:0]     first_idx;
  logic                trap_hit;
  logic                timeout;
  logic                to_idle;
  logic                go_grace;

  assign trap_edge = trap_i & ~trap_q;

  iob_prio_enc #(
    .W     (N_TRAP),
    .IDX_W (FT_W)
  ) u_prio (
    .vec (trap_edge),
    .idx (first_idx),
    .hit (trap_hit)
  );

  // A zero TIMEOUT_CYCLES compiles the watchdog comparison away.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state == ST_RUN) && !activity_i &&
                   (wdog == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  assign to_idle  = (state_n == ST_IDLE);
  assign go_grace = (state == ST_RUN) && (state_n == ST_GRACE);

  // Next-state decode; clear_i beats everything, losing en_i beats events.
  always_comb begin
    state_n = state;
    if (clear_i) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (en_i) state_n = ST_RUN;
        ST_RUN: begin
          if (!en_i)                   state_n = ST_IDLE;
          else if (trap_hit || timeout) state_n = ST_GRACE;
        end
        ST_GRACE: if (grace_cnt == '0) state_n = ST_DONE;
        ST_DONE:  state_n = ST_DONE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     state <= ST_IDLE;
    else if (cke_i) state <= state_n;
  end

  // Trap history held at zero through IDLE so a level already high on RUN
  // entry is seen as a fresh edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     trap_q <= '0;
    else if (cke_i) trap_q <= (state == ST_IDLE || to_idle) ? '0 : trap_i;
  end

  // Watchdog: counts idle RUN cycles, kicked back to zero by activity_i.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wdog <= '0;
    end else if (cke_i) begin
      if (to_idle)              wdog <= '0;
      else if (state == ST_RUN) wdog <= activity_i ? '0 : wdog + 1'b1;
    end
  end

  // Grace countdown; the cycle that sees zero is the last GRACE cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      grace_cnt <= '0;
    end else if (cke_i) begin
      if (to_idle)                                   grace_cnt <= '0;
      else if (go_grace)                             grace_cnt <= GC_W'(GRACE_CYCLES);
      else if (state == ST_GRACE && grace_cnt != '0) grace_cnt <= grace_cnt - 1'b1;
    end
  end

  // Saturating RUN-cycle counter.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cycle_cnt_o <= '0;
    end else if (cke_i) begin
      if (to_idle)                                   cycle_cnt_o <= '0;
      else if (state == ST_RUN && cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 1'b1;
    end
  end

  // Finish report: latched on RUN exit, late traps accumulate during GRACE.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cause_o      <= CAUSE_NONE;
      trap_mask_o  <= '0;
      first_trap_o <= '0;
    end else if (cke_i) begin
      if (to_idle) begin
        cause_o      <= CAUSE_NONE;
        trap_mask_o  <= '0;
        first_trap_o <= '0;
      end else if (go_grace) begin
        cause_o     <= {timeout, trap_hit};
        trap_mask_o <= trap_edge;
        if (trap_hit) first_trap_o <= first_idx;
      end else if (state == ST_GRACE) begin
        trap_mask_o <= trap_mask_o | trap_edge;
      end
    end
  end

  // done_o registered from the next state so it tracks DONE exactly.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     done_o <= 1'b0;
    else if (cke_i) done_o <= (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_iob_sim_trap_monitor.sv
// Directed bench for iob_sim_trap_monitor (N_TRAP=2, GRACE=10, TIMEOUT=100).
module tb_iob_sim_trap_monitor;
  import iob_sim_trap_monitor_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i, cke_i, en_i, clear_i, activity_i;
  logic [1:0]  trap_i;
  logic        done_o;
  logic [1:0]  cause_o;
  logic [1:0]  trap_mask_o;
  logic [0:0]  first_trap_o;
  logic [31:0] cycle_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  iob_sim_trap_monitor #(
    .N_TRAP         (2),
    .GRACE_CYCLES   (10),
    .TIMEOUT_W      (32),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .cke_i        (cke_i),
    .en_i         (en_i),
    .clear_i      (clear_i),
    .trap_i       (trap_i),
    .activity_i   (activity_i),
    .done_o       (done_o),
    .cause_o      (cause_o),
    .trap_mask_o  (trap_mask_o),
    .first_trap_o (first_trap_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  32'(done_o),       32'd0);
    chk({tag, "_cause"}, 32'(cause_o),      32'd0);
    chk({tag, "_mask"},  32'(trap_mask_o),  32'd0);
    chk({tag, "_first"}, 32'(first_trap_o), 32'd0);
    chk({tag, "_cnt"},   cycle_cnt_o,       32'd0);
  endtask

  initial begin
    arst_i = 1'b1; cke_i = 1'b1; en_i = 1'b0; clear_i = 1'b0;
    activity_i = 1'b0; trap_i = 2'b00;
    step(3);
    chk_all_zero("reset");
    chk("reset_state", 32'(dut.state), 32'(ST_IDLE));
    arst_i = 1'b0;
    step(2);
    chk("idle_no_en_state", 32'(dut.state), 32'(ST_IDLE));

    // Single trap on trap_i[1] during the 50th RUN cycle.
    en_i = 1'b1;
    step(1);
    chk("t1_run_cnt0", cycle_cnt_o, 32'd0);
    step(49);
    chk("t1_cnt49", cycle_cnt_o, 32'd49);
    trap_i = 2'b10;
    step(1);
    chk("t1_cause", 32'(cause_o), 32'd1);
    chk("t1_mask", 32'(trap_mask_o), 32'd2);
    chk("t1_first", 32'(first_trap_o), 32'd1);
    chk("t1_cnt", cycle_cnt_o, 32'd50);
    step(10);
    chk("t1_done_early", 32'(done_o), 32'd0);
    step(1);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_cnt_hold", cycle_cnt_o, 32'd50);
    step(3);
    chk("t1_done_sticky", 32'(done_o), 32'd1);
    chk("t1_cause_hold", 32'(cause_o), 32'd1);
    clear_i = 1'b1; trap_i = 2'b00;
    step(1);
    clear_i = 1'b0;
    chk("t1_clear_done", 32'(done_o), 32'd0);
    chk("t1_clear_cnt", cycle_cnt_o, 32'd0);

    // Both traps: [0] first, [1] three cycles later, inside GRACE.
    step(1);
    step(5);
    trap_i = 2'b01;
    step(1);
    chk("t2_first0", 32'(first_trap_o), 32'd0);
    chk("t2_mask01", 32'(trap_mask_o), 32'd1);
    step(2);
    trap_i = 2'b11;
    step(1);
    chk("t2_mask11", 32'(trap_mask_o), 32'd3);
    step(7);
    chk("t2_done_early", 32'(done_o), 32'd0);
    step(1);
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_mask_done", 32'(trap_mask_o), 32'd3);
    chk("t2_first_done", 32'(first_trap_o), 32'd0);
    chk("t2_cause", 32'(cause_o), 32'd1);
    clear_i = 1'b1; trap_i = 2'b00; en_i = 1'b0;
    step(1);
    clear_i = 1'b0;

    // Timeout: kick during RUN cycle 40, then silence for 100 cycles.
    en_i = 1'b1;
    step(1);
    step(39);
    activity_i = 1'b1;
    step(1);
    activity_i = 1'b0;
    step(99);
    chk("t3_no_timeout_yet", 32'(cause_o), 32'd0);
    chk("t3_still_run", 32'(dut.state), 32'(ST_RUN));
    step(1);
    chk("t3_cause", 32'(cause_o), 32'd2);
    chk("t3_mask", 32'(trap_mask_o), 32'd0);
    chk("t3_cnt", cycle_cnt_o, 32'd140);
    step(11);
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_cause_done", 32'(cause_o), 32'd2);
    clear_i = 1'b1; en_i = 1'b0;
    step(1);
    clear_i = 1'b0;

    // Trap edges on the timeout cycle itself.
    en_i = 1'b1;
    step(1);
    step(99);
    chk("t4_pre_cause", 32'(cause_o), 32'd0);
    trap_i = 2'b11;
    step(1);
    chk("t4_cause_both", 32'(cause_o), 32'd3);
    chk("t4_first", 32'(first_trap_o), 32'd0);
    chk("t4_mask", 32'(trap_mask_o), 32'd3);
    clear_i = 1'b1; trap_i = 2'b00; en_i = 1'b0;
    step(1);
    clear_i = 1'b0;

    // Async reset with the grace counter at 5.
    en_i = 1'b1;
    step(1);
    step(3);
    trap_i = 2'b01;
    step(1);
    chk("t5_in_grace", 32'(dut.state), 32'(ST_GRACE));
    step(5);
    chk("t5_grace5", 32'(dut.grace_cnt), 32'd5);
    arst_i = 1'b1;
    #1;
    chk_all_zero("t5_arst");
    chk("t5_arst_state", 32'(dut.state), 32'(ST_IDLE));
    en_i = 1'b0; trap_i = 2'b00;
    step(1);
    arst_i = 1'b0;
    step(2);
    chk("t5_stay_idle", 32'(dut.state), 32'(ST_IDLE));

    // Clock enable low freezes counters and edge detection.
    en_i = 1'b1;
    step(1);
    step(10);
    chk("t6_cnt10", cycle_cnt_o, 32'd10);
    cke_i = 1'b0;
    step(10);
    trap_i = 2'b01;
    step(10);
    chk("t6_cke_hold_cnt", cycle_cnt_o, 32'd10);
    chk("t6_cke_hold_cause", 32'(cause_o), 32'd0);
    cke_i = 1'b1;
    step(1);
    chk("t6_resume_cnt", cycle_cnt_o, 32'd11);
    chk("t6_resume_cause", 32'(cause_o), 32'd1);
    clear_i = 1'b1; en_i = 1'b0;
    step(1);
    clear_i = 1'b0;

    // Pre-asserted trap while idle, then clear from DONE.
    trap_i = 2'b01;
    step(3);
    chk("t7_idle_cause", 32'(cause_o), 32'd0);
    en_i = 1'b1;
    step(1);
    chk("t7_run", 32'(dut.state), 32'(ST_RUN));
    step(1);
    chk("t7_grace", 32'(dut.state), 32'(ST_GRACE));
    chk("t7_cause", 32'(cause_o), 32'd1);
    chk("t7_mask", 32'(trap_mask_o), 32'd1);
    chk("t7_cnt", cycle_cnt_o, 32'd1);
    step(11);
    chk("t7_done", 32'(done_o), 32'd1);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("t7_clear_done", 32'(done_o), 32'd0);
    chk("t7_clear_state", 32'(dut.state), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
